// File: rtl/uart_tx_arbiter_if.sv
// ----------------------------------------------------------------------------
// uart_tx_arbiter_if
// Purpose : Bundles the requester side and the transmitter side of the UART
//           transmit arbiter into one interface.
// Signals : req/req_data/ack         - byte sources (one bit/byte per source)
//           tx_data/tx_int           - byte and launch strobe to the transmitter
//           send_complete            - transmitter status (1 idle/done, 0 sending)
//           busy/grant_id/err_timeout- arbiter status
//           lock                     - only when UART_ARB_LOCK_EN is defined
// Modports: master - the arbiter itself
//           slave  - sources / transmitter / testbench side
// ----------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
   parameter int NUM_REQ = 4
);

   logic [NUM_REQ-1:0]   req;
   logic [8*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]   ack;
   logic [7:0]           tx_data;
   logic                 tx_int;
   logic                 send_complete;
   logic                 busy;
   logic [2:0]           grant_id;
   logic                 err_timeout;
`ifdef UART_ARB_LOCK_EN
   logic [NUM_REQ-1:0]   lock;
`endif

   modport master (
`ifdef UART_ARB_LOCK_EN
      input  lock,
`endif
      input  req,
      input  req_data,
      input  send_complete,
      output ack,
      output tx_data,
      output tx_int,
      output busy,
      output grant_id,
      output err_timeout
   );

   modport slave (
`ifdef UART_ARB_LOCK_EN
      output lock,
`endif
      output req,
      output req_data,
      output send_complete,
      input  ack,
      input  tx_data,
      input  tx_int,
      input  busy,
      input  grant_id,
      input  err_timeout
   );

endinterface

// File: rtl/uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// uart_tx_arbiter
// Purpose : Round-robin scheduler that shares one UART byte transmitter among
//           NUM_REQ byte sources. Grants a requester, latches its byte onto
//           tx_data, raises tx_int for INT_HOLD cycles and drops it to launch
//           the transmitter, then follows send_complete low (started) and
//           high (done) before the next grant.
// Ports   : clk    - system clock
//           rst_n  - asynchronous active-low reset
//           bus    - uart_tx_arbiter_if.master (req, req_data, ack, tx_data,
//                    tx_int, send_complete, busy, grant_id, err_timeout,
//                    and lock when enabled)
// Config  : UART_ARB_LOCK_EN - when defined, a locked requester that is still
//           requesting keeps the round-robin pointer at DONE so a multi-byte
//           frame goes out uninterleaved. A timeout always advances.
// ----------------------------------------------------------------------------
module uart_tx_arbiter #(
   parameter int NUM_REQ       = 4,
   parameter int INT_HOLD      = 2,
   parameter int START_TIMEOUT = 64
) (
   input logic               clk,
   input logic               rst_n,
   uart_tx_arbiter_if.master bus
);

   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] LOAD      = 2'd1;
   localparam logic [1:0] FIRE      = 2'd2;
   localparam logic [1:0] WAIT_DONE = 2'd3;

   localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

   logic [1:0] state;
   logic [2:0] rr_ptr;
   logic [7:0] hold_cnt;
   logic [6:0] tmo_cnt;

   logic       found;
   logic [2:0] win;
   logic [7:0] win_data;
   logic [2:0] next_ptr;
   logic       keep_ptr;

   // Round-robin search: walk offsets from the highest down so the lowest
   // offset from rr_ptr with an active request is the one left standing.
   always_comb begin
      found = 1'b0;
      win   = rr_ptr;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if ((i == ((int'(rr_ptr) + k) % NUM_REQ)) && bus.req[i]) begin
               found = 1'b1;
               win   = 3'(i);
            end
         end
      end
   end

   // Byte of the winning requester, picked with constant slices.
   always_comb begin
      win_data = 8'h00;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (3'(i) == win) begin
            win_data = bus.req_data[8*i +: 8];
         end
      end
   end

   // Pointer value that moves past the requester that was just served.
   always_comb begin
      next_ptr = (bus.grant_id == 3'(NUM_REQ - 1)) ? 3'd0 : bus.grant_id + 3'd1;
   end

   // Lock hold: stay on the current requester only while it is both locked
   // and still asking for the bus.
`ifdef UART_ARB_LOCK_EN
   always_comb begin
      keep_ptr = |(bus.lock & bus.req & (ONE_HOT0 << bus.grant_id));
   end
`else
   always_comb begin
      keep_ptr = 1'b0;
   end
`endif

   assign bus.busy = (state != IDLE);

   // Main sequencer. ack and err_timeout default low every cycle so they can
   // only ever be single-cycle pulses; tx_data and grant_id only change on a
   // grant, which keeps the byte frozen through LOAD, FIRE and WAIT_DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         rr_ptr          <= 3'd0;
         hold_cnt        <= 8'd0;
         tmo_cnt         <= 7'd0;
         bus.ack         <= '0;
         bus.tx_data     <= 8'h00;
         bus.tx_int      <= 1'b0;
         bus.grant_id    <= 3'd0;
         bus.err_timeout <= 1'b0;
      end else begin
         bus.ack         <= '0;
         bus.err_timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (found && bus.send_complete) begin
                  bus.tx_data  <= win_data;
                  bus.grant_id <= win;
                  bus.ack      <= ONE_HOT0 << win;
                  bus.tx_int   <= 1'b1;
                  hold_cnt     <= 8'd0;
                  state        <= LOAD;
               end
            end
            LOAD: begin
               if (hold_cnt == 8'(INT_HOLD - 1)) begin
                  bus.tx_int <= 1'b0;
                  tmo_cnt    <= 7'd0;
                  state      <= FIRE;
               end else begin
                  hold_cnt <= hold_cnt + 8'd1;
               end
            end
            FIRE: begin
               if (!bus.send_complete) begin
                  state <= WAIT_DONE;
               end else if (tmo_cnt == 7'(START_TIMEOUT - 1)) begin
                  bus.err_timeout <= 1'b1;
                  rr_ptr          <= next_ptr;
                  state           <= IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + 7'd1;
               end
            end
            WAIT_DONE: begin
               if (bus.send_complete) begin
                  rr_ptr <= keep_ptr ? bus.grant_id : next_ptr;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Purpose : Directed self-checking bench for uart_tx_arbiter (NUM_REQ=4,
//           INT_HOLD=2, START_TIMEOUT=64). Inputs change and outputs are
//           observed on the falling clock edge.
// Config  : follows UART_ARB_LOCK_EN for the lock scenario.
// ----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

   localparam int NR = 4;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   uart_tx_arbiter_if #(.NUM_REQ(NR)) bus ();

   uart_tx_arbiter #(
      .NUM_REQ      (NR),
      .INT_HOLD     (2),
      .START_TIMEOUT(64)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.master)
   );

   // 50 MHz clock
   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   // Hard stop in case some wait below is ever left unbounded.
   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Drive all inputs to idle values and pulse reset; returns on a falling edge.
   task automatic do_reset();
      rst_n              = 1'b0;
      bus.req            = '0;
      bus.req_data       = '0;
      bus.send_complete  = 1'b1;
`ifdef UART_ARB_LOCK_EN
      bus.lock           = '0;
`endif
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Transmitter model for one byte: wait for an ack, optionally drop the
   // acked request, wait for tx_int to fall, pull send_complete low two
   // cycles later and keep it low for ten cycles.
   task automatic serve_byte(input bit clear_on_ack, output logic [2:0] gid,
                             output logic [7:0] txd, output logic [NR-1:0] ackv,
                             output bit ok);
      ok   = 1'b0;
      gid  = 3'd0;
      txd  = 8'h00;
      ackv = '0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.ack != '0) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) return;
      ackv = bus.ack;
      gid  = bus.grant_id;
      txd  = bus.tx_data;
      if (clear_on_ack) bus.req = bus.req & ~bus.ack;
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.tx_int == 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) return;
      repeat (2) @(negedge clk);
      bus.send_complete = 1'b0;
      repeat (10) @(negedge clk);
      bus.send_complete = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      checks += 6;
      if (bus.ack !== 4'b0000) begin failures++; $display("[TB] FAIL reset_ack got=%b exp=0000", bus.ack); end
      if (bus.tx_data !== 8'h00) begin failures++; $display("[TB] FAIL reset_tx_data got=%h exp=00", bus.tx_data); end
      if (bus.tx_int !== 1'b0) begin failures++; $display("[TB] FAIL reset_tx_int got=%b exp=0", bus.tx_int); end
      if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", bus.busy); end
      if (bus.grant_id !== 3'd0) begin failures++; $display("[TB] FAIL reset_grant_id got=%0d exp=0", bus.grant_id); end
      if (bus.err_timeout !== 1'b0) begin failures++; $display("[TB] FAIL reset_err got=%b exp=0", bus.err_timeout); end
   endtask

   task automatic test_single_grant();
      @(negedge clk);
      bus.req      = 4'b0100;
      bus.req_data = 32'h11A5_3322;
      @(negedge clk);
      checks += 5;
      if (bus.ack !== 4'b0100) begin failures++; $display("[TB] FAIL single_ack got=%b exp=0100", bus.ack); end
      if (bus.tx_data !== 8'hA5) begin failures++; $display("[TB] FAIL single_tx_data got=%h exp=a5", bus.tx_data); end
      if (bus.tx_int !== 1'b1) begin failures++; $display("[TB] FAIL single_tx_int_t1 got=%b exp=1", bus.tx_int); end
      if (bus.grant_id !== 3'd2) begin failures++; $display("[TB] FAIL single_grant_id got=%0d exp=2", bus.grant_id); end
      if (bus.busy !== 1'b1) begin failures++; $display("[TB] FAIL single_busy got=%b exp=1", bus.busy); end
      bus.req      = 4'b0001;
      bus.req_data = 32'hFFFF_FFFF;
      @(negedge clk);
      checks += 2;
      if (bus.tx_int !== 1'b1) begin failures++; $display("[TB] FAIL single_tx_int_t2 got=%b exp=1", bus.tx_int); end
      if (bus.ack !== 4'b0000) begin failures++; $display("[TB] FAIL single_ack_pulse got=%b exp=0000", bus.ack); end
      @(negedge clk);
      checks += 3;
      if (bus.tx_int !== 1'b0) begin failures++; $display("[TB] FAIL single_tx_int_fall got=%b exp=0", bus.tx_int); end
      if (bus.tx_data !== 8'hA5) begin failures++; $display("[TB] FAIL single_frozen got=%h exp=a5", bus.tx_data); end
      if (bus.ack !== 4'b0000) begin failures++; $display("[TB] FAIL single_req_ignored got=%b exp=0000", bus.ack); end
      bus.req           = '0;
      bus.send_complete = 1'b0;
      @(negedge clk);
      checks += 1;
      if (bus.busy !== 1'b1) begin failures++; $display("[TB] FAIL single_busy_wait got=%b exp=1", bus.busy); end
      bus.send_complete = 1'b1;
      @(negedge clk);
      checks += 2;
      if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL single_done_busy got=%b exp=0", bus.busy); end
      if (bus.tx_data !== 8'hA5) begin failures++; $display("[TB] FAIL single_done_data got=%h exp=a5", bus.tx_data); end
   endtask

   task automatic test_round_robin();
      logic [2:0]    gid;
      logic [7:0]    txd;
      logic [NR-1:0] ackv;
      bit            ok;
      int            exp_ord [5] = '{0, 1, 2, 3, 0};
      logic [7:0]    exp_byte [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
      do_reset();
      bus.req      = 4'b1111;
      bus.req_data = 32'h4433_2211;
      for (int n = 0; n < 5; n++) begin
         serve_byte(1'b0, gid, txd, ackv, ok);
         checks += 4;
         if (!ok) begin failures++; $display("[TB] FAIL rr_timeout byte=%0d got=no_ack exp=ack", n); end
         if (gid !== 3'(exp_ord[n])) begin failures++; $display("[TB] FAIL rr_grant byte=%0d got=%0d exp=%0d", n, gid, exp_ord[n]); end
         if (ackv !== (4'b0001 << exp_ord[n])) begin failures++; $display("[TB] FAIL rr_ack byte=%0d got=%b exp=%b", n, ackv, 4'b0001 << exp_ord[n]); end
         if (txd !== exp_byte[exp_ord[n]]) begin failures++; $display("[TB] FAIL rr_data byte=%0d got=%h exp=%h", n, txd, exp_byte[exp_ord[n]]); end
      end
      bus.req = '0;
   endtask

   task automatic test_timeout();
      logic [2:0]    gid;
      logic [7:0]    txd;
      logic [NR-1:0] ackv;
      bit            ok;
      int            n;
      int            k;
      do_reset();
      bus.req      = 4'b0001;
      bus.req_data = 32'h0000_00C3;
      @(negedge clk);
      checks += 1;
      if (bus.ack !== 4'b0001) begin failures++; $display("[TB] FAIL tmo_ack got=%b exp=0001", bus.ack); end
      bus.req = '0;
      n = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         n++;
         if (bus.tx_int == 1'b0) break;
      end
      checks += 1;
      if (n != 2) begin failures++; $display("[TB] FAIL tmo_int_fall got=%0d exp=2", n); end
      k = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         k++;
         if (bus.err_timeout == 1'b1) break;
      end
      checks += 2;
      if (k != 64) begin failures++; $display("[TB] FAIL tmo_delay got=%0d exp=64", k); end
      if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL tmo_busy got=%b exp=0", bus.busy); end
      @(negedge clk);
      checks += 1;
      if (bus.err_timeout !== 1'b0) begin failures++; $display("[TB] FAIL tmo_pulse got=%b exp=0", bus.err_timeout); end
      bus.req = 4'b0011;
      serve_byte(1'b1, gid, txd, ackv, ok);
      checks += 2;
      if (!ok) begin failures++; $display("[TB] FAIL tmo_next_ack got=no_ack exp=ack"); end
      if (gid !== 3'd1) begin failures++; $display("[TB] FAIL tmo_next_grant got=%0d exp=1", gid); end
      bus.req = '0;
   endtask

   task automatic test_idle_hold();
      bit viol;
      @(negedge clk);
      bus.send_complete = 1'b0;
      bus.req           = 4'b0001;
      bus.req_data      = 32'h0000_005A;
      viol = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (bus.ack != '0 || bus.tx_int || bus.busy) viol = 1'b1;
      end
      checks += 1;
      if (viol !== 1'b0) begin failures++; $display("[TB] FAIL hold_no_grant got=%b exp=0", viol); end
      bus.send_complete = 1'b1;
      @(negedge clk);
      checks += 3;
      if (bus.ack !== 4'b0001) begin failures++; $display("[TB] FAIL hold_ack got=%b exp=0001", bus.ack); end
      if (bus.tx_int !== 1'b1) begin failures++; $display("[TB] FAIL hold_tx_int got=%b exp=1", bus.tx_int); end
      if (bus.tx_data !== 8'h5A) begin failures++; $display("[TB] FAIL hold_data got=%h exp=5a", bus.tx_data); end
      bus.req = '0;
      repeat (2) @(negedge clk);
      bus.send_complete = 1'b0;
      @(negedge clk);
      bus.send_complete = 1'b1;
      @(negedge clk);
      checks += 1;
      if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL hold_done got=%b exp=0", bus.busy); end
   endtask

   task automatic test_reset_mid();
      logic [2:0]    gid;
      logic [7:0]    txd;
      logic [NR-1:0] ackv;
      bit            ok;
      @(negedge clk);
      bus.req = 4'b0010;
      @(negedge clk);
      checks += 1;
      if (bus.ack !== 4'b0010) begin failures++; $display("[TB] FAIL rmid_ack got=%b exp=0010", bus.ack); end
      bus.req = '0;
      repeat (2) @(negedge clk);
      bus.send_complete = 1'b0;
      repeat (2) @(negedge clk);
      checks += 1;
      if (bus.busy !== 1'b1) begin failures++; $display("[TB] FAIL rmid_busy_before got=%b exp=1", bus.busy); end
      #2 rst_n = 1'b0;
      #1;
      checks += 4;
      if (bus.tx_int !== 1'b0) begin failures++; $display("[TB] FAIL rmid_tx_int got=%b exp=0", bus.tx_int); end
      if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL rmid_busy got=%b exp=0", bus.busy); end
      if (bus.ack !== 4'b0000) begin failures++; $display("[TB] FAIL rmid_ack0 got=%b exp=0000", bus.ack); end
      if (bus.grant_id !== 3'd0) begin failures++; $display("[TB] FAIL rmid_grant_id got=%0d exp=0", bus.grant_id); end
      @(negedge clk);
      bus.send_complete = 1'b1;
      rst_n             = 1'b1;
      bus.req           = 4'b1111;
      serve_byte(1'b1, gid, txd, ackv, ok);
      checks += 2;
      if (!ok) begin failures++; $display("[TB] FAIL rmid_regrant got=no_ack exp=ack"); end
      if (gid !== 3'd0) begin failures++; $display("[TB] FAIL rmid_rr_ptr got=%0d exp=0", gid); end
      bus.req = '0;
   endtask

   task automatic test_lock();
      logic [2:0]    gid;
      logic [7:0]    txd;
      logic [NR-1:0] ackv;
      bit            ok;
`ifdef UART_ARB_LOCK_EN
      int            exp_ord [4] = '{1, 1, 1, 0};
      do_reset();
      bus.req = 4'b0001;
      serve_byte(1'b1, gid, txd, ackv, ok);
      checks += 1;
      if (gid !== 3'd0 || !ok) begin failures++; $display("[TB] FAIL lock_pre got=%0d exp=0", gid); end
      bus.req  = 4'b0011;
      bus.lock = 4'b0010;
      for (int n = 0; n < 4; n++) begin
         serve_byte(1'b0, gid, txd, ackv, ok);
         if (n == 2) bus.lock = '0;
         checks += 1;
         if (gid !== 3'(exp_ord[n]) || !ok) begin failures++; $display("[TB] FAIL lock_grant byte=%0d got=%0d exp=%0d", n, gid, exp_ord[n]); end
      end
`else
      int            exp_ord [4] = '{0, 1, 0, 1};
      do_reset();
      bus.req = 4'b0011;
      for (int n = 0; n < 4; n++) begin
         serve_byte(1'b0, gid, txd, ackv, ok);
         checks += 1;
         if (gid !== 3'(exp_ord[n]) || !ok) begin failures++; $display("[TB] FAIL nolock_grant byte=%0d got=%0d exp=%0d", n, gid, exp_ord[n]); end
      end
`endif
      bus.req = '0;
   endtask

   // Scenarios run in order; later ones rely on the pointer left by earlier.
   initial begin
      checks   = 0;
      failures = 0;
      $display("[TB] start");
      test_reset();
      test_single_grant();
      test_round_robin();
      test_timeout();
      test_idle_hold();
      test_reset_mid();
      test_lock();
      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
